freq_result_filter: RTL and testbench

Downstream consumer of the frequency-count stage, running entirely in the clk100 domain. It accepts one count sample per gate window through a valid pulse and averages 2^AVG_LOG2 consecutive samples. It tracks min/max and flags out-of-range averages and unread overwrites. It presents a held result with a valid/ack handshake to the slave-register read path.

---
 rtl/freq_result_filter.sv | 182 ++++++++++++++++++
 tb/tb_freq_result_filter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_result_filter.sv
`default_nettype none
// ============================================================================
// Module      : freq_result_filter
// Description : Averages 2^AVG_LOG2 frequency-count samples. Tracks the
//               unsigned min/max of accepted samples. Flags out-of-range
//               averages and overwritten unread results. Holds the published
//               average behind a valid/ack handshake.
// Options     : FREQ_FILT_ROUND_EN - round half up before the shift
//               (otherwise truncate)
// Revision    : 1.0 - initial release
// ============================================================================
module freq_result_filter #(
  parameter int          DATA_W   = 32,
  parameter int          AVG_LOG2 = 3,
  parameter int unsigned LO_LIMIT = 0,
  parameter int unsigned HI_LIMIT = 100000000
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic [DATA_W-1:0] meas_count,
  input  logic              meas_valid,
  input  logic              clear_stats,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] avg_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic              result_valid,
  output logic              overrun,
  output logic              range_err
);

  localparam int                ACC_W   = DATA_W + AVG_LOG2;
  localparam int                N_W     = AVG_LOG2 + 1;
  localparam logic [N_W-1:0]    C_N_ONE = N_W'(1);
  localparam logic [N_W-1:0]    C_WIN   = C_N_ONE << AVG_LOG2;
  localparam logic [DATA_W-1:0] C_LO    = DATA_W'(LO_LIMIT);
  localparam logic [DATA_W-1:0] C_HI    = DATA_W'(HI_LIMIT);

  typedef enum logic [0:0] {
    S_ACCUM   = 1'b0,
    S_PUBLISH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic              rv_q, rv_d;
  logic              ovr_q, ovr_d;
  logic              rerr_q, rerr_d;

  logic [ACC_W-1:0]  w_bias;
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_avg;
  logic              w_below;
  logic              w_above;
  logic              w_pub;
  logic [ACC_W-1:0]  w_acc_base;
  logic [N_W-1:0]    w_n_base;
  logic [N_W-1:0]    w_n_inc;

`ifdef FREQ_FILT_ROUND_EN
  // Half an LSB of the averaged result; meaningless for a 1-sample window
  if (AVG_LOG2 > 0) begin : g_round
    assign w_bias = ACC_W'(1) << (AVG_LOG2 - 1);
  end else begin : g_no_round
    assign w_bias = '0;
  end
`else
  assign w_bias = '0;
`endif

  // The biased sum still fits ACC_W bits: the worst-case window sum
  // leaves 2^AVG_LOG2-1 of headroom.
  assign w_sum = acc_q + w_bias;
  assign w_avg = DATA_W'(w_sum >> AVG_LOG2);

  // A leading 1 on both sides keeps the ordering unchanged and avoids
  // comparing against a constant zero when LO_LIMIT is 0.
  assign w_below = {1'b1, w_avg} < {1'b1, C_LO};
  assign w_above = {1'b1, w_avg} > {1'b1, C_HI};

  // The publish cycle restarts the window. A sample arriving in that
  // cycle becomes sample 1 of the next window.
  assign w_pub      = (state_q == S_PUBLISH);
  assign w_acc_base = w_pub ? '0 : acc_q;
  assign w_n_base   = w_pub ? '0 : n_q;
  assign w_n_inc    = w_n_base + C_N_ONE;

  // Next-state logic: accumulate, publish, handshake and statistics clear
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    avg_d   = avg_q;
    min_d   = min_q;
    max_d   = max_q;
    rv_d    = rv_q;
    ovr_d   = ovr_q;
    rerr_d  = rerr_q;

    if (rd_ack && rv_q) begin
      rv_d = 1'b0;
    end

    if (clear_stats) begin
      // Discard the current window and any pending publish; keep the result
      state_d = S_ACCUM;
      acc_d   = '0;
      n_d     = '0;
      min_d   = '1;
      max_d   = '0;
      ovr_d   = 1'b0;
      rerr_d  = 1'b0;
    end else begin
      state_d = S_ACCUM;
      acc_d   = w_acc_base;
      n_d     = w_n_base;
      if (w_pub) begin
        avg_d = w_avg;
        rv_d  = 1'b1;
        if (rv_q && !rd_ack) begin
          ovr_d = 1'b1;
        end
        if (w_below || w_above) begin
          rerr_d = 1'b1;
        end
      end
      if (meas_valid) begin
        acc_d = w_acc_base + ACC_W'(meas_count);
        if (meas_count < min_q) begin
          min_d = meas_count;
        end
        if (meas_count > max_q) begin
          max_d = meas_count;
        end
        if (w_n_inc == C_WIN) begin
          state_d = S_PUBLISH;
          n_d     = '0;
        end else begin
          n_d = w_n_inc;
        end
      end
    end
  end

  // State and result registers with asynchronous reset
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state_q <= S_ACCUM;
      acc_q   <= '0;
      n_q     <= '0;
      avg_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      avg_q   <= avg_d;
      min_q   <= min_d;
      max_q   <= max_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
      rerr_q  <= rerr_d;
    end
  end

  assign avg_out      = avg_q;
  assign min_out      = min_q;
  assign max_out      = max_q;
  assign result_valid = rv_q;
  assign overrun      = ovr_q;
  assign range_err    = rerr_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_result_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_result_filter
// Description : Directed self-checking bench for freq_result_filter. A
//               window model pushes expected averages to a queue as samples
//               are driven. Each expected average is popped and compared
//               when the DUT publishes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_result_filter;

  localparam int DATA_W   = 32;
  localparam int AVG_LOG2 = 3;
  localparam int WIN      = 1 << AVG_LOG2;
  localparam int LO       = 1000;
  localparam int HI       = 100000000;
`ifdef FREQ_FILT_ROUND_EN
  localparam longint BIAS = 4;
`else
  localparam longint BIAS = 0;
`endif

  logic              clk100      = 1'b0;
  logic              reset       = 1'b1;
  logic [DATA_W-1:0] meas_count  = '0;
  logic              meas_valid  = 1'b0;
  logic              clear_stats = 1'b0;
  logic              rd_ack      = 1'b0;
  logic [DATA_W-1:0] avg_out;
  logic [DATA_W-1:0] min_out;
  logic [DATA_W-1:0] max_out;
  logic              result_valid;
  logic              overrun;
  logic              range_err;

  freq_result_filter #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2),
    .LO_LIMIT (LO),
    .HI_LIMIT (HI)
  ) dut (
    .clk100       (clk100),
    .reset        (reset),
    .meas_count   (meas_count),
    .meas_valid   (meas_valid),
    .clear_stats  (clear_stats),
    .rd_ack       (rd_ack),
    .avg_out      (avg_out),
    .min_out      (min_out),
    .max_out      (max_out),
    .result_valid (result_valid),
    .overrun      (overrun),
    .range_err    (range_err)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint      m_sum;
  int          m_n;
  logic [31:0] m_min, m_max, m_avg;
  logic        m_rv, m_ovr, m_rerr;
  logic [31:0] sb[$];

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = 0; m_n = 0; m_min = '1; m_max = '0;
    m_avg = '0; m_rv = 1'b0; m_ovr = 1'b0; m_rerr = 1'b0;
    sb.delete();
  endtask

  task automatic model_clear();
    m_sum = 0; m_n = 0; m_min = '1; m_max = '0;
    m_ovr = 1'b0; m_rerr = 1'b0;
    sb.delete();
  endtask

  task automatic model_add(input logic [31:0] v);
    m_sum += longint'(v);
    m_n++;
    if (v < m_min) m_min = v;
    if (v > m_max) m_max = v;
    if (m_n == WIN) begin
      sb.push_back(32'((m_sum + BIAS) >> AVG_LOG2));
      m_sum = 0;
      m_n   = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk ({tag, ".avg"},  avg_out,      m_avg);
    chk ({tag, ".min"},  min_out,      m_min);
    chk ({tag, ".max"},  max_out,      m_max);
    chkb({tag, ".rv"},   result_valid, m_rv);
    chkb({tag, ".ovr"},  overrun,      m_ovr);
    chkb({tag, ".rerr"}, range_err,    m_rerr);
  endtask

  task automatic sample(input logic [31:0] v);
    meas_count = v;
    meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    model_add(v);
  endtask

  task automatic window(input logic [31:0] v);
    for (int i = 0; i < WIN; i++) sample(v);
  endtask

  // Publish cycle: optional rd_ack and optional new sample in the same cycle
  task automatic publish(input string tag, input logic ack, input logic pv, input logic [31:0] pval);
    logic [31:0] exp;
    rd_ack     = ack;
    meas_valid = pv;
    meas_count = pval;
    tick();
    rd_ack     = 1'b0;
    meas_valid = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      if (m_rv && !ack) m_ovr = 1'b1;
      m_rv  = 1'b1;
      m_avg = exp;
      if (exp < 32'(LO) || exp > 32'(HI)) m_rerr = 1'b1;
      if (pv) model_add(pval);
      check_all(tag);
    end
  endtask

  task automatic ack(input string tag);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    m_rv = 1'b0;
    chkb({tag, ".rv"}, result_valid, 1'b0);
  endtask

  task automatic clear();
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_all("reset");

    // Eight samples at the upper limit, spaced ten cycles apart
    for (int i = 0; i < WIN; i++) begin
      sample(32'd100000000);
      if (i < WIN - 1) repeat (9) tick();
    end
    chkb("hi.rv_early", result_valid, 1'b0);
    publish("hi", 1'b0, 1'b0, '0);
    ack("hi_ack");

    // Ramp 1..8: truncated (or rounded) average
    clear();
    for (int i = 1; i <= WIN; i++) sample(32'(i));
    publish("ramp", 1'b0, 1'b0, '0);
    clear();
    check_all("ramp_clr");
    ack("ramp_ack");

    // Two windows without an ack: overrun, newest wins
    clear();
    window(32'd10);
    publish("ovr1", 1'b0, 1'b0, '0);
    window(32'd20);
    publish("ovr2", 1'b0, 1'b0, '0);
    ack("ovr_ack");
    chkb("ovr_sticky", overrun, 1'b1);
    clear();
    chkb("ovr_clr", overrun, 1'b0);

    // Ack coincident with publish; sample in the publish cycle
    window(32'd2000);
    publish("pa1", 1'b0, 1'b0, '0);
    window(32'd3000);
    publish("pa2", 1'b1, 1'b1, 32'd4000);
    for (int i = 0; i < WIN - 2; i++) sample(32'd4000);
    tick(); tick();
    chk ("pa_hold.avg", avg_out, 32'd3000);
    sample(32'd4000);
    publish("pa3", 1'b1, 1'b0, '0);
    ack("pa_ack");

    // clear_stats coincident with a sample discards it
    clear();
    for (int i = 0; i < 5; i++) sample(32'd5000);
    meas_count  = 32'd9999;
    meas_valid  = 1'b1;
    clear_stats = 1'b1;
    tick();
    meas_valid  = 1'b0;
    clear_stats = 1'b0;
    model_clear();
    check_all("clr_coinc");
    for (int i = 0; i < WIN - 1; i++) sample(32'd6000);
    tick(); tick();
    chkb("clr_nopub.rv", result_valid, 1'b0);
    sample(32'd6000);
    publish("clr_pub", 1'b0, 1'b0, '0);

    // Lower-limit boundary, then below range
    ack("lo_ack");
    clear();
    window(32'd1000);
    publish("lo_edge", 1'b0, 1'b0, '0);
    window(32'd500);
    publish("lo_below", 1'b0, 1'b0, '0);

    // Asynchronous reset mid-window, between clock edges
    ack("ar_ack");
    clear();
    for (int i = 0; i < 3; i++) sample(32'd7000);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("areset");
    reset = 1'b0;
    tick();
    window(32'd7000);
    publish("post_rst", 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
